stl2sts_param: RTL
==================

# stl2sts_param

Parametrised Avalon-ST width down-converter: accepts wide packet beats of RATIO×OUT_W bits and emits RATIO narrow beats of OUT_W bits, MSB symbol first. It generalises the fixed 32→16 stage in the sensor streaming path by adding configurable width and ratio, correct `empty` propagation with trailing-beat suppression, and full-throughput back-to-back operation. It sits between the wide packetiser output and narrow downstream sinks (FIFO/DMA) in the Qsys system.

## Interface
- OUT_W, 16, output data width in bits (multiple of SYM_W)
- RATIO, 2, input/output width ratio (≥2); IN_W = OUT_W*RATIO
- SYM_W, 8, Avalon symbol width in bits
- Derived: IN_SYM = IN_W/SYM_W, OUT_SYM = OUT_W/SYM_W, EI_W = clog2(IN_SYM), EO_W = max(1, clog2(OUT_SYM))

- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in_data  in  IN_W  wide beat, first symbol in MSBs
- data_in_valid  in  1  sink valid
- data_in_ready  out  1  sink ready (readyLatency 0)
- data_in_empty  in  EI_W  empty symbols, meaningful only with eop
- data_in_startofpacket  in  1
- data_in_endofpacket  in  1
- data_out_data  out  OUT_W  narrow beat
- data_out_valid  out  1
- data_out_ready  in  1  readyLatency 0
- data_out_empty  out  EO_W
- data_out_startofpacket  out  1
- data_out_endofpacket  out  1
- pkt_err  out  1  sticky protocol error (see Configuration)

## Operation
- Input beat accepted when data_in_valid && data_in_ready; captured into holding register with sop, eop, empty.
- Beat count N: non-eop beat → N = RATIO; eop beat → V = IN_SYM − empty, N = ceil(V/OUT_SYM) (1..RATIO). Trailing all-empty slices never emitted.
- States: IDLE (holding empty, data_out_valid=0) and EMIT (slice index k, width clog2(RATIO)).
- IDLE → EMIT on accept, k=0. In EMIT, on output handshake: k<N−1 → k+1; k=N−1 → accept next beat if presented (stay EMIT, k=0) else IDLE.
- data_in_ready = (state==IDLE) || (k==N−1 && data_out_ready). Combinational from data_out_ready; no other comb paths.
- Slice k = holding[IN_W−1−k*OUT_W −: OUT_W].
- data_out_startofpacket = held sop && k==0. data_out_endofpacket = held eop && k==N−1.
- data_out_empty = N*OUT_SYM − V on eop slice, else 0. Empty symbols in output carry don't-care data (pass through held bits).
- data_out_* stable while data_out_valid && !data_out_ready.
- data_in_empty ignored on non-eop beats.

## Timing
- Reset: state IDLE, k=0, data_out_valid=0, data_out_data=0, data_out_empty=0, sop=eop=0, pkt_err=0; data_in_ready=1 after reset deassert.
- Latency: first slice valid the cycle after input accept.
- Throughput: with data_out_ready held 1, no bubbles; one input beat per N cycles.
- Reset asserted mid-packet: holding discarded, outputs return to reset values asynchronously; no partial packet completion afterwards.
- Simultaneous last-slice handshake and new input: both in same cycle; new slice 0 presented next cycle.

## Configuration
- STL2STS_PKT_CHECK_EN defined: track in-packet flag; sets pkt_err (sticky until reset) on accepted sop while in packet, non-sop beat while not in packet, or empty ≥ IN_SYM on eop beat (treated as empty = IN_SYM−1 for emission). Data path unchanged.
- Not defined: checker absent, pkt_err tied 0.

## Structure
- Package stl2sts_pkg: clog2 function, state enum/localparams (ST_IDLE, ST_EMIT), derived-width helper for N and output empty.
- One sub-module natural: stl2sts_pkt_chk (packet framing checker), instantiated only under STL2STS_PKT_CHECK_EN.

## Test plan
(OUT_W=16, RATIO=2, SYM_W=8; data shown hex)
- 0x11223344 sop, 0x55667788 eop empty=0, ready=1 -> 1122(sop), 3344, 5566, 7788(eop, empty=0) on four consecutive cycles; data_in_ready high every second cycle.
- eop beat 0xAABBCCxx empty=1 -> AABB, then CCxx eop empty=1.
- eop beat 0xDDEExxxx empty=2 -> single DDEE eop empty=0; next packet's sop beat accepted same cycle, its slice 0 next cycle.
- data_out_ready pattern 1,0,1,0… over 3-beat packet -> all 6 slices delivered in order, outputs unchanged during stalls, no drops/duplicates.
- rst low during slice 1 of a packet -> data_out_valid=0 immediately; after release, fresh packet 0x01020304 sop/eop -> 0102(sop), 0304(eop) only.
- With STL2STS_PKT_CHECK_EN: eop beat with no preceding sop -> pkt_err=1 next cycle, stays 1 until reset; without macro pkt_err=0 throughout.

Source files
------------

// File: rtl/stl2sts_pkg.sv
// Shared types and width helpers for the stl2sts width down-converter.
// Beat-count and output-empty arithmetic live here so the top stays readable.
package stl2sts_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_EMIT
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Empty fields are never zero-width, even when a beat holds a single symbol.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (clog2(v) > 1) ? clog2(v) : 1;
    endfunction

    function automatic int unsigned beat_count(input int unsigned vsym, input int unsigned out_sym);
        return (vsym + out_sym - 1) / out_sym;
    endfunction

    function automatic int unsigned slice_empty(input int unsigned vsym,
                                                input int unsigned out_sym);
        return beat_count(vsym, out_sym) * out_sym - vsym;
    endfunction

endpackage

// File: rtl/stl2sts_param_if.sv
// Avalon-ST sink (wide) and source (narrow) signal bundle for stl2sts_param.
// slave is the converter's view; master is the view of the surrounding system.
interface stl2sts_param_if #(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned RATIO = 2,
    parameter int unsigned SYM_W = 8
);
    import stl2sts_pkg::*;

    localparam int unsigned IN_W    = OUT_W * RATIO;
    localparam int unsigned IN_SYM  = IN_W / SYM_W;
    localparam int unsigned OUT_SYM = OUT_W / SYM_W;
    localparam int unsigned EI_W    = clog2(IN_SYM);
    localparam int unsigned EO_W    = clog2_min1(OUT_SYM);

    logic [IN_W-1:0]  data_in_data;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [EI_W-1:0]  data_in_empty;
    logic             data_in_startofpacket;
    logic             data_in_endofpacket;

    logic [OUT_W-1:0] data_out_data;
    logic             data_out_valid;
    logic             data_out_ready;
    logic [EO_W-1:0]  data_out_empty;
    logic             data_out_startofpacket;
    logic             data_out_endofpacket;

    modport slave (
        input  data_in_data, data_in_valid, data_in_empty,
        input  data_in_startofpacket, data_in_endofpacket, data_out_ready,
        output data_in_ready, data_out_data, data_out_valid, data_out_empty,
        output data_out_startofpacket, data_out_endofpacket
    );

    modport master (
        output data_in_data, data_in_valid, data_in_empty,
        output data_in_startofpacket, data_in_endofpacket, data_out_ready,
        input  data_in_ready, data_out_data, data_out_valid, data_out_empty,
        input  data_out_startofpacket, data_out_endofpacket
    );

endinterface

// File: rtl/stl2sts_pkt_chk.sv
// Packet framing checker: flags sop inside a packet, a non-sop beat outside a packet,
// or an out-of-range empty on an eop beat. The error is sticky until reset.
module stl2sts_pkt_chk #(
    parameter int unsigned IN_SYM = 4,
    parameter int unsigned EI_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            accept_i,
    input  logic            sop_i,
    input  logic            eop_i,
    input  logic [EI_W-1:0] empty_i,
    output logic            pkt_err_o
);

    logic in_pkt_q, in_pkt_d;
    logic err_q, err_d;

    always_comb begin
        in_pkt_d = in_pkt_q;
        err_d    = err_q;
        if (accept_i) begin
            if ((sop_i && in_pkt_q) || (!sop_i && !in_pkt_q) ||
                (eop_i && (32'(empty_i) >= IN_SYM))) begin
                err_d = 1'b1;
            end
            in_pkt_d = !eop_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
        end
    end

    assign pkt_err_o = err_q;

endmodule

// File: rtl/stl2sts_param.sv
// Avalon-ST width down-converter: one wide beat becomes up to RATIO narrow beats, MSB first,
// trailing all-empty slices suppressed. Define STL2STS_PKT_CHECK_EN to add the framing checker.
module stl2sts_param
    import stl2sts_pkg::*;
#(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned RATIO = 2,
    parameter int unsigned SYM_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    stl2sts_param_if.slave  bus,
    output logic            pkt_err
);

    localparam int unsigned IN_W    = OUT_W * RATIO;
    localparam int unsigned IN_SYM  = IN_W / SYM_W;
    localparam int unsigned OUT_SYM = OUT_W / SYM_W;
    localparam int unsigned EI_W    = clog2(IN_SYM);
    localparam int unsigned EO_W    = clog2_min1(OUT_SYM);
    localparam int unsigned KW      = clog2(RATIO);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d, last_q, last_d, last_new;
    logic [IN_W-1:0]  hold_q, hold_d;
    logic             sop_q, sop_d, eop_q, eop_d;
    logic [EO_W-1:0]  oemp_q, oemp_d, oemp_new;
    logic [EI_W-1:0]  emp_eff;
    int unsigned      vsym;
    int unsigned      base;
    logic             accept, out_hs, at_last;

    assign at_last = (k_q == last_q);
    assign out_hs  = (state_q == ST_EMIT) && bus.data_out_ready;
    assign accept  = bus.data_in_valid && bus.data_in_ready;

    // Out-of-range empty is clamped so a malformed eop beat still emits one slice.
    always_comb begin
        emp_eff = bus.data_in_empty;
        if (32'(bus.data_in_empty) >= IN_SYM) emp_eff = EI_W'(IN_SYM - 1);
        vsym = IN_SYM - 32'(emp_eff);
        if (bus.data_in_endofpacket) begin
            last_new = KW'(beat_count(vsym, OUT_SYM) - 1);
            oemp_new = EO_W'(slice_empty(vsym, OUT_SYM));
        end else begin
            last_new = KW'(RATIO - 1);
            oemp_new = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_EMIT;
            ST_EMIT: if (out_hs && at_last && !accept) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        sop_d  = sop_q;
        eop_d  = eop_q;
        last_d = last_q;
        oemp_d = oemp_q;
        k_d    = k_q;
        if (accept) begin
            hold_d = bus.data_in_data;
            sop_d  = bus.data_in_startofpacket;
            eop_d  = bus.data_in_endofpacket;
            last_d = last_new;
            oemp_d = oemp_new;
            k_d    = '0;
        end else if (out_hs) begin
            k_d = at_last ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            last_q <= '0;
            oemp_q <= '0;
            k_q    <= '0;
        end else begin
            hold_q <= hold_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
            last_q <= last_d;
            oemp_q <= oemp_d;
            k_q    <= k_d;
        end
    end

    always_comb begin
        base                       = IN_W - 1 - 32'(k_q) * OUT_W;
        bus.data_in_ready          = (state_q == ST_IDLE) || (at_last && bus.data_out_ready);
        bus.data_out_valid         = (state_q == ST_EMIT);
        bus.data_out_data          = hold_q[base -: OUT_W];
        bus.data_out_startofpacket = bus.data_out_valid && sop_q && (k_q == '0);
        bus.data_out_endofpacket   = bus.data_out_valid && eop_q && at_last;
        bus.data_out_empty         = bus.data_out_endofpacket ? oemp_q : '0;
    end

`ifdef STL2STS_PKT_CHECK_EN
    stl2sts_pkt_chk #(
        .IN_SYM (IN_SYM),
        .EI_W   (EI_W)
    ) u_pkt_chk (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .sop_i     (bus.data_in_startofpacket),
        .eop_i     (bus.data_in_endofpacket),
        .empty_i   (bus.data_in_empty),
        .pkt_err_o (pkt_err)
    );
`else
    assign pkt_err = 1'b0;
`endif

endmodule
